// File: rtl/cvblob_pkg.sv
// Shared types, channel indices and width helper for the blob centroid block.
package cvblob_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDiv
    } state_e;

    localparam int unsigned PINK  = 0;
    localparam int unsigned GREEN = 1;

    // Ceiling log2; used to size coordinate, count and sum fields.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < longint'(v)) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cvblob_centroid_if.sv
// Mask-stream input and centroid-result bundle for cvblob_centroid.
// Bounding-box outputs exist only when CVBLOB_BBOX_EN is defined.
interface cvblob_centroid_if #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
);
    import cvblob_pkg::*;

    localparam int unsigned XW = clog2(IMG_W);
    localparam int unsigned YW = clog2(IMG_H);
    localparam int unsigned CW = clog2(IMG_W * IMG_H + 1);

    logic          pix_valid;
    logic          sof;
    logic [15:0]   mask;
    logic          busy;
    logic          overrun;
    logic          result_valid;
    logic [1:0]    found;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
    logic [XW-1:0] cx0;
    logic [YW-1:0] cy0;
    logic [XW-1:0] cx1;
    logic [YW-1:0] cy1;
`ifdef CVBLOB_BBOX_EN
    logic [XW-1:0] xmin0, xmax0, xmin1, xmax1;
    logic [YW-1:0] ymin0, ymax0, ymin1, ymax1;
`endif

`ifdef CVBLOB_BBOX_EN
    modport master (
        output pix_valid, sof, mask,
        input  busy, overrun, result_valid, found, count0, count1, cx0, cy0, cx1, cy1,
        input  xmin0, xmax0, ymin0, ymax0, xmin1, xmax1, ymin1, ymax1
    );
    modport slave (
        input  pix_valid, sof, mask,
        output busy, overrun, result_valid, found, count0, count1, cx0, cy0, cx1, cy1,
        output xmin0, xmax0, ymin0, ymax0, xmin1, xmax1, ymin1, ymax1
    );
`else
    modport master (
        output pix_valid, sof, mask,
        input  busy, overrun, result_valid, found, count0, count1, cx0, cy0, cx1, cy1
    );
    modport slave (
        input  pix_valid, sof, mask,
        output busy, overrun, result_valid, found, count0, count1, cx0, cy0, cx1, cy1
    );
`endif

endinterface

// File: rtl/cvblob_div.sv
// Fixed-latency restoring radix-2 divider. start loads the operands and performs the
// first iteration in the same cycle; done pulses SW cycles after start with the
// quotient valid. A zero divisor yields quotient 0.
module cvblob_div
    import cvblob_pkg::*;
#(
    parameter int unsigned SW = 12,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic [SW-1:0] quotient,
    output logic          done
);
    localparam int unsigned NW = clog2(SW + 1);

    logic [CW-1:0] rem_q, rem_d, rem_in;
    logic [SW-1:0] quo_q, quo_d, quo_in;
    logic [CW-1:0] dvs_q, dvs_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [CW:0]   shifted;
    logic          step;

    // One shift/compare/subtract iteration per cycle while the counter runs.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_d   = start ? divisor : dvs_q;
        step    = start || (cnt_q != '0);
        shifted = {rem_in, quo_in[SW-1]};
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        if (step) begin
            if (shifted >= {1'b0, dvs_d}) begin
                rem_d = CW'(shifted - {1'b0, dvs_d});
                quo_d = {quo_in[SW-2:0], 1'b1};
            end else begin
                rem_d = shifted[CW-1:0];
                quo_d = {quo_in[SW-2:0], 1'b0};
            end
            cnt_d = start ? NW'(SW - 1) : cnt_q - NW'(1);
        end
        done_d = step && (cnt_d == '0);
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = (dvs_q == '0) ? '0 : quo_q;
    assign done     = done_q;

endmodule

// File: rtl/cvblob_centroid.sv
// Per-frame pink/green blob accumulator with a shared sequential divider that
// produces integer centroids. Optional bounding boxes under CVBLOB_BBOX_EN.
module cvblob_centroid
    import cvblob_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    cvblob_centroid_if.slave bus
);
    localparam int unsigned XW = clog2(IMG_W);
    localparam int unsigned YW = clog2(IMG_H);
    localparam int unsigned CW = clog2(IMG_W * IMG_H + 1);
    localparam int unsigned SW = XW + CW;
    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [SW-1:0] sx_q [2];
    logic [SW-1:0] sx_d [2];
    logic [SW-1:0] sy_q [2];
    logic [SW-1:0] sy_d [2];
    logic [1:0]    op_q, op_d, div_sel;
    logic          first_q, first_d;
    logic [XW-1:0] q0_q, q0_d, q2_q, q2_d;
    logic [YW-1:0] q1_q, q1_d;
    logic          rv_q, rv_d;
    logic [1:0]    found_q, found_d;
    logic [CW-1:0] count0_q, count0_d, count1_q, count1_d;
    logic [XW-1:0] cx0_q, cx0_d, cx1_q, cx1_d;
    logic [YW-1:0] cy0_q, cy0_d, cy1_q, cy1_d;
    logic          beat_take;
    logic [1:0]    hit;
    logic          div_start, div_done;
    logic [SW-1:0] div_dividend, div_quot;
    logic [CW-1:0] div_divisor;
`ifdef CVBLOB_BBOX_EN
    logic [XW-1:0] xmin_q [2];
    logic [XW-1:0] xmin_d [2];
    logic [XW-1:0] xmax_q [2];
    logic [XW-1:0] xmax_d [2];
    logic [YW-1:0] ymin_q [2];
    logic [YW-1:0] ymin_d [2];
    logic [YW-1:0] ymax_q [2];
    logic [YW-1:0] ymax_d [2];
    logic [XW-1:0] oxmin_q [2];
    logic [XW-1:0] oxmin_d [2];
    logic [XW-1:0] oxmax_q [2];
    logic [XW-1:0] oxmax_d [2];
    logic [YW-1:0] oymin_q [2];
    logic [YW-1:0] oymin_d [2];
    logic [YW-1:0] oymax_q [2];
    logic [YW-1:0] oymax_d [2];
`endif

    cvblob_div #(
        .SW(SW),
        .CW(CW)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .quotient(div_quot),
        .done    (div_done)
    );

    // Next-state: pixel accumulation, frame control and division sequencing.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        op_d     = op_q;
        first_d  = 1'b0;
        q0_d     = q0_q;
        q1_d     = q1_q;
        q2_d     = q2_q;
        rv_d     = 1'b0;
        found_d  = found_q;
        count0_d = count0_q;
        count1_d = count1_q;
        cx0_d    = cx0_q;
        cy0_d    = cy0_q;
        cx1_d    = cx1_q;
        cy1_d    = cy1_q;
`ifdef CVBLOB_BBOX_EN
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        oxmin_d = oxmin_q;
        oxmax_d = oxmax_q;
        oymin_d = oymin_q;
        oymax_d = oymax_q;
`endif
        div_start = 1'b0;
        hit       = {|bus.mask[15:8], |bus.mask[7:0]};
        x_cur     = bus.sof ? '0 : x_q;
        y_cur     = bus.sof ? '0 : y_q;
        // sof is accepted in every state (it restarts or aborts); other beats only in ACCUM.
        beat_take = bus.pix_valid && (bus.sof || (state_q == StAccum));

        if (beat_take) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.sof) begin
                    cnt_d[k] = '0;
                    sx_d[k]  = '0;
                    sy_d[k]  = '0;
`ifdef CVBLOB_BBOX_EN
                    xmin_d[k] = '1;
                    xmax_d[k] = '0;
                    ymin_d[k] = '1;
                    ymax_d[k] = '0;
`endif
                end
                if (hit[k]) begin
                    cnt_d[k] = cnt_d[k] + CW'(1);
                    sx_d[k]  = sx_d[k] + SW'(x_cur);
                    sy_d[k]  = sy_d[k] + SW'(y_cur);
`ifdef CVBLOB_BBOX_EN
                    if (x_cur < xmin_d[k]) xmin_d[k] = x_cur;
                    if (x_cur > xmax_d[k]) xmax_d[k] = x_cur;
                    if (y_cur < ymin_d[k]) ymin_d[k] = y_cur;
                    if (y_cur > ymax_d[k]) ymax_d[k] = y_cur;
`endif
                end
            end
            if (x_cur == XLast) begin
                x_d = '0;
                y_d = (y_cur == YLast) ? '0 : y_cur + YW'(1);
            end else begin
                x_d = x_cur + XW'(1);
                y_d = y_cur;
            end
            op_d = 2'd0;
            if ((x_cur == XLast) && (y_cur == YLast)) begin
                state_d = StDiv;
                first_d = 1'b1;
            end else begin
                state_d = StAccum;
            end
        end else if (state_q == StDiv) begin
            // Chain the next division in the cycle the previous one completes.
            div_start = first_q || (div_done && (op_q != 2'd3));
            if (div_done) begin
                op_d = op_q + 2'd1;
                unique case (op_q)
                    2'd0: q0_d = XW'(div_quot);
                    2'd1: q1_d = YW'(div_quot);
                    2'd2: q2_d = XW'(div_quot);
                    2'd3: begin
                        rv_d     = 1'b1;
                        state_d  = StIdle;
                        found_d  = {cnt_q[GREEN] != '0, cnt_q[PINK] != '0};
                        count0_d = cnt_q[PINK];
                        count1_d = cnt_q[GREEN];
                        cx0_d    = q0_q;
                        cy0_d    = q1_q;
                        cx1_d    = q2_q;
                        cy1_d    = YW'(div_quot);
`ifdef CVBLOB_BBOX_EN
                        for (int k = 0; k < 2; k++) begin
                            oxmin_d[k] = (cnt_q[k] == '0) ? '0 : xmin_q[k];
                            oxmax_d[k] = (cnt_q[k] == '0) ? '0 : xmax_q[k];
                            oymin_d[k] = (cnt_q[k] == '0) ? '0 : ymin_q[k];
                            oymax_d[k] = (cnt_q[k] == '0) ? '0 : ymax_q[k];
                        end
`endif
                    end
                endcase
            end
        end

        // Operand order: sumx0, sumy0, sumx1, sumy1.
        div_sel = first_q ? 2'd0 : op_q + 2'd1;
        unique case (div_sel)
            2'd0: div_dividend = sx_q[PINK];
            2'd1: div_dividend = sy_q[PINK];
            2'd2: div_dividend = sx_q[GREEN];
            2'd3: div_dividend = sy_q[GREEN];
        endcase
        div_divisor = div_sel[1] ? cnt_q[GREEN] : cnt_q[PINK];
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '{default: '0};
            sx_q     <= '{default: '0};
            sy_q     <= '{default: '0};
            op_q     <= '0;
            first_q  <= 1'b0;
            q0_q     <= '0;
            q1_q     <= '0;
            q2_q     <= '0;
            rv_q     <= 1'b0;
            found_q  <= '0;
            count0_q <= '0;
            count1_q <= '0;
            cx0_q    <= '0;
            cy0_q    <= '0;
            cx1_q    <= '0;
            cy1_q    <= '0;
`ifdef CVBLOB_BBOX_EN
            xmin_q  <= '{default: '0};
            xmax_q  <= '{default: '0};
            ymin_q  <= '{default: '0};
            ymax_q  <= '{default: '0};
            oxmin_q <= '{default: '0};
            oxmax_q <= '{default: '0};
            oymin_q <= '{default: '0};
            oymax_q <= '{default: '0};
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            op_q     <= op_d;
            first_q  <= first_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            q2_q     <= q2_d;
            rv_q     <= rv_d;
            found_q  <= found_d;
            count0_q <= count0_d;
            count1_q <= count1_d;
            cx0_q    <= cx0_d;
            cy0_q    <= cy0_d;
            cx1_q    <= cx1_d;
            cy1_q    <= cy1_d;
`ifdef CVBLOB_BBOX_EN
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            oxmin_q <= oxmin_d;
            oxmax_q <= oxmax_d;
            oymin_q <= oymin_d;
            oymax_q <= oymax_d;
`endif
        end
    end

    assign bus.busy         = (state_q == StDiv);
    assign bus.overrun      = (state_q == StDiv) && bus.pix_valid && !bus.sof;
    assign bus.result_valid = rv_q;
    assign bus.found        = found_q;
    assign bus.count0       = count0_q;
    assign bus.count1       = count1_q;
    assign bus.cx0          = cx0_q;
    assign bus.cy0          = cy0_q;
    assign bus.cx1          = cx1_q;
    assign bus.cy1          = cy1_q;
`ifdef CVBLOB_BBOX_EN
    assign bus.xmin0 = oxmin_q[PINK];
    assign bus.xmax0 = oxmax_q[PINK];
    assign bus.ymin0 = oymin_q[PINK];
    assign bus.ymax0 = oymax_q[PINK];
    assign bus.xmin1 = oxmin_q[GREEN];
    assign bus.xmax1 = oxmax_q[GREEN];
    assign bus.ymin1 = oymin_q[GREEN];
    assign bus.ymax1 = oymax_q[GREEN];
`endif

endmodule

// File: tb/tb_cvblob_centroid.sv
// Scoreboard bench for cvblob_centroid on a 16x8 image (result latency 50 cycles).
module tb_cvblob_centroid;

    localparam int IMG_W = 16;
    localparam int IMG_H = 8;
    localparam int LAT   = 50;

    typedef struct {
        int cyc;
        int found;
        int c0, cx0, cy0, c1, cx1, cy1;
        int xmin0, xmax0, ymin0, ymax0, xmin1, xmax1, ymin1, ymax1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    int   last_t = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cvblob_centroid_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    cvblob_centroid #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix_mask(input int scen, input int x, input int y);
        case (scen)
            0: return (x == 10 && y == 5) ? 16'h0040 : 16'h0000;
            1: return 16'hFFFF;
            2: return (x >= 4 && x <= 7 && y >= 2 && y <= 3) ? 16'h2000 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Hand-computed results for each stimulus pattern.
    function automatic exp_t exp_of(input int scen, input int c);
        exp_t e;
        e.cyc = c;
        case (scen)
            0: begin
                e.found = 1; e.c0 = 1; e.cx0 = 10; e.cy0 = 5;
                e.xmin0 = 10; e.xmax0 = 10; e.ymin0 = 5; e.ymax0 = 5;
            end
            1: begin
                e.found = 3;
                e.c0 = 128; e.cx0 = 7; e.cy0 = 3; e.c1 = 128; e.cx1 = 7; e.cy1 = 3;
                e.xmin0 = 0; e.xmax0 = 15; e.ymin0 = 0; e.ymax0 = 7;
                e.xmin1 = 0; e.xmax1 = 15; e.ymin1 = 0; e.ymax1 = 7;
            end
            2: begin
                e.found = 2; e.c1 = 8; e.cx1 = 5; e.cy1 = 2;
                e.xmin1 = 4; e.xmax1 = 7; e.ymin1 = 2; e.ymax1 = 3;
            end
            default: e.found = 0;
        endcase
        return e;
    endfunction

    task automatic beat(input logic s, input logic [15:0] m);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        bus.mask      = m;
        last_t        = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.pix_valid = 1'b0;
            bus.sof       = 1'b0;
            bus.mask      = 16'h0000;
        end
    endtask

    // Drives n raster pixels starting at (0,0) with sof, with periodic gaps.
    task automatic send_frame(input int scen, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            if (i % 9 == 4) idle(1);
            beat(i == 0, pix_mask(scen, i % IMG_W, i / IMG_W));
        end
        idle(1);
        if (push) exp_q.push_back(exp_of(scen, last_t + LAT));
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got no result_valid, required %0d pending", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    // Monitor: counts overrun pulses and checks each result against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.overrun) ovr_seen++;
            if (bus.result_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got result_valid at cycle %0d, required none",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc, e.cyc);
                    check("found", int'(bus.found), e.found);
                    check("count0", int'(bus.count0), e.c0);
                    check("cx0", int'(bus.cx0), e.cx0);
                    check("cy0", int'(bus.cy0), e.cy0);
                    check("count1", int'(bus.count1), e.c1);
                    check("cx1", int'(bus.cx1), e.cx1);
                    check("cy1", int'(bus.cy1), e.cy1);
`ifdef CVBLOB_BBOX_EN
                    check("xmin0", int'(bus.xmin0), e.xmin0);
                    check("xmax0", int'(bus.xmax0), e.xmax0);
                    check("ymin0", int'(bus.ymin0), e.ymin0);
                    check("ymax0", int'(bus.ymax0), e.ymax0);
                    check("xmin1", int'(bus.xmin1), e.xmin1);
                    check("xmax1", int'(bus.xmax1), e.xmax1);
                    check("ymin1", int'(bus.ymin1), e.ymin1);
                    check("ymax1", int'(bus.ymax1), e.ymax1);
`endif
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_result_valid"}, int'(bus.result_valid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
        check({tag, "_found"}, int'(bus.found), 0);
        check({tag, "_count0"}, int'(bus.count0), 0);
        check({tag, "_count1"}, int'(bus.count1), 0);
        check({tag, "_cx0"}, int'(bus.cx0), 0);
        check({tag, "_cy0"}, int'(bus.cy0), 0);
        check({tag, "_cx1"}, int'(bus.cx1), 0);
        check({tag, "_cy1"}, int'(bus.cy1), 0);
    endtask

    // Directed stimulus.
    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.mask      = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Beats without sof in IDLE are ignored and never flag overrun.
        beat(1'b0, 16'hFFFF);
        beat(1'b0, 16'hFFFF);
        idle(1);

        send_frame(0, IMG_W * IMG_H, 1'b1);
        wait_results();
        send_frame(1, IMG_W * IMG_H, 1'b1);
        wait_results();
        send_frame(2, IMG_W * IMG_H, 1'b1);
        wait_results();

        // Non-sof beats during DIV are dropped with an overrun pulse each.
        send_frame(0, IMG_W * IMG_H, 1'b1);
        idle(5);
        @(negedge clk);
        check("busy_in_div", int'(bus.busy), 1);
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 16'hFFFF);
            ovr_exp++;
        end
        idle(1);
        wait_results();

        // sof during DIV aborts the division; the new frame completes normally.
        send_frame(2, IMG_W * IMG_H, 1'b0);
        idle(10);
        send_frame(1, IMG_W * IMG_H, 1'b1);
        @(negedge clk);
        check("held_count0", int'(bus.count0), 1);
        check("held_cx0", int'(bus.cx0), 10);
        check("held_count1", int'(bus.count1), 0);
        wait_results();

        // sof mid-frame at pixel 40 discards the partial frame.
        send_frame(1, 40, 1'b0);
        send_frame(2, IMG_W * IMG_H, 1'b1);
        wait_results();

        // Asynchronous reset mid-DIV clears everything at once.
        send_frame(1, IMG_W * IMG_H, 1'b0);
        idle(20);
        #2 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(0, IMG_W * IMG_H, 1'b1);
        wait_results();

        check("overrun_pulses", ovr_seen, ovr_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
